// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a shared SRAM data port
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int ADDR_WIDTH = 18
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_sign,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_sign,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_sign,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_we;
    logic        r_sign;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_ack;
    logic [1:0]  r_err;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_any;
    logic        w_sel;
    logic        w_we;
    logic        w_sign;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_bad;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_any   = m0_req | m1_req;
        w_sel   = (m0_req && m1_req) ? ~r_last_grant : m1_req;
        w_we    = w_sel ? m1_we    : m0_we;
        w_sign  = w_sel ? m1_sign  : m0_sign;
        w_size  = w_sel ? m1_size  : m0_size;
        w_addr  = w_sel ? m1_addr  : m0_addr;
        w_wdata = w_sel ? m1_wdata : m0_wdata;
        w_bad   = ((w_addr >> ADDR_WIDTH) != 32'd0)
               || (w_size == 2'b11)
               || ((w_size == 2'b01) && w_addr[0])
               || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_sign       <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
            r_rdata0     <= 32'd0;
            r_rdata1     <= 32'd0;
        end else begin
            r_ack <= 2'b00;
            r_err <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_sel;
                        r_last_grant <= w_sel;
                        r_we         <= w_we;
                        r_sign       <= w_sign;
                        r_size       <= w_size;
                        r_addr       <= w_addr;
                        r_wdata      <= w_wdata;
                        if (w_bad) begin
                            r_state       <= S_DONE;
                            r_ack[w_sel]  <= 1'b1;
                            r_err[w_sel]  <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_state        <= S_DONE;
                        r_ack[r_grant] <= 1'b1;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (r_grant) r_rdata1 <= mem_rdata;
                    else         r_rdata0 <= mem_rdata;
                    r_state        <= S_DONE;
                    r_ack[r_grant] <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Decoded from state so the strobes drop the instant reset asserts.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_sign  = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (r_state == S_ACCESS) begin
            mem_read  = ~r_we;
            mem_write = r_we;
            mem_sign  = r_sign;
            mem_size  = r_size;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end else if (r_state == S_CAPTURE) begin
            mem_sign  = r_sign;
            mem_size  = r_size;
            mem_addr  = r_addr;
        end
    end

    assign m0_ack   = r_ack[0];
    assign m1_ack   = r_ack[1];
    assign m0_err   = r_err[0];
    assign m1_err   = r_err[1];
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte-addressed SRAM model
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int AW = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_sign = 0;
    logic [1:0]  m0_size = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 0, m1_we = 0, m1_sign = 0;
    logic [1:0]  m1_size = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_read, mem_write, mem_sign;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0BAD_F00D;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sign(m0_sign), .m0_size(m0_size),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sign(m1_sign), .m1_size(m1_size),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_sign(mem_sign),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          strobe_cnt = 0;
    int          exp_strobes = 0;
    logic [31:0] exp_rdata [2];
    logic [7:0]  sram [logic [31:0]];
    logic [7:0]  gold [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice(input logic [1:0] size, input logic sgn, input logic [31:0] w);
        case (size)
            2'b00:   return sgn ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   return sgn ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [7:0] sbyte(input logic [31:0] a);
        return sram.exists(a) ? sram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] gbyte(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : 8'h00;
    endfunction

    // SRAM responder: writes land at the edge, sliced read data is valid the next cycle.
    always @(posedge clk) begin
        if (rst_n && (mem_read || mem_write)) strobe_cnt++;
        if (mem_write) begin
            sram[mem_addr] = mem_wdata[7:0];
            if (mem_size != 2'b00) sram[mem_addr + 1] = mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                sram[mem_addr + 2] = mem_wdata[23:16];
                sram[mem_addr + 3] = mem_wdata[31:24];
            end
        end
        mem_rdata <= mem_read ? slice(mem_size, mem_sign,
                        {sbyte(mem_addr + 3), sbyte(mem_addr + 2), sbyte(mem_addr + 1), sbyte(mem_addr)})
                     : 32'h0BAD_F00D;
    end

    task automatic issue(input int port, input logic we, input logic sgn, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input int extra, input bit push);
        exp_t e;
        logic bad;
        bad = (addr >= (32'd1 << AW)) || (size == 2'b11) || ((size == 2'b01) && addr[0])
           || ((size == 2'b10) && (addr[1:0] != 2'b00));
        if (port == 0) begin
            m0_we = we; m0_sign = sgn; m0_size = size; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_sign = sgn; m1_size = size; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        if (push) begin
            e.port = port;
            e.err  = bad;
            e.lat  = (bad ? 1 : (we ? 2 : 3)) + extra;
            if (!bad) exp_strobes++;
            if (!bad && !we)
                exp_rdata[port] = slice(size, sgn,
                    {gbyte(addr + 3), gbyte(addr + 2), gbyte(addr + 1), gbyte(addr)});
            if (!bad && we) begin
                gold[addr] = wdata[7:0];
                if (size != 2'b00) gold[addr + 1] = wdata[15:8];
                if (size == 2'b10) begin
                    gold[addr + 2] = wdata[23:16];
                    gold[addr + 3] = wdata[31:24];
                end
            end
            e.rdata = exp_rdata[port];
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        exp_t        e;
        int          cyc = 0;
        int          got = 0;
        int          p;
        logic [31:0] idle_bits;
        while (got < n && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack || m1_ack) begin
                p = m1_ack ? 1 : 0;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("grant_port", p, e.port);
                    chk("latency", cyc, e.lat);
                    chk("err", p ? m1_err : m0_err, e.err);
                    chk("rdata", p ? m1_rdata : m0_rdata, e.rdata);
                end
                if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
                got++;
            end
        end
        if (got < n) chk("ack_timeout", got, n);
        @(posedge clk); #1;
        idle_bits = mem_addr | mem_wdata | {26'h0, m0_ack, m1_ack, mem_read, mem_write, mem_sign, mem_size[1] | mem_size[0]};
        chk("idle_outputs", idle_bits, 32'd0);
        chk("strobe_count", strobe_cnt, exp_strobes);
    endtask

    task automatic do_reset();
        m0_req = 1'b0; m1_req = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        logic [31:0] outs;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        #2;
        outs = m0_rdata | m1_rdata | mem_addr | mem_wdata
             | {26'h0, m0_ack, m0_err, m1_ack, m1_err, mem_read | mem_write | mem_sign, mem_size[0] | mem_size[1]};
        chk("reset_outputs", outs, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 0, 1'b1);   run(1);
        issue(1, 1'b0, 1'b0, 2'b00, 32'h11, 32'h0, 0, 1'b1);          run(1);
        chk("byte_signed_value", m1_rdata, 32'hFFFFFFBE);
        issue(1, 1'b0, 1'b1, 2'b01, 32'h12, 32'h0, 0, 1'b1);          run(1);
        issue(0, 1'b0, 1'b0, 2'b01, 32'h12, 32'h0, 0, 1'b1);          run(1);

        issue(0, 1'b0, 1'b0, 2'b01, 32'h3, 32'h0, 0, 1'b1);           run(1);
        issue(0, 1'b0, 1'b0, 2'b10, 32'h40000, 32'h0, 0, 1'b1);       run(1);
        issue(1, 1'b1, 1'b0, 2'b11, 32'h20, 32'h1234, 0, 1'b1);       run(1);
        issue(0, 1'b1, 1'b0, 2'b10, 32'h3FFFC, 32'hCAFE0123, 0, 1'b1); run(1);
        issue(1, 1'b0, 1'b0, 2'b10, 32'h3FFFC, 32'h0, 0, 1'b1);       run(1);

        do_reset();
        issue(0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h11111111, 0, 1'b1);
        issue(1, 1'b1, 1'b0, 2'b10, 32'h24, 32'h22222222, 3, 1'b1);   run(2);
        issue(0, 1'b1, 1'b0, 2'b10, 32'h28, 32'h33333333, 0, 1'b1);
        issue(1, 1'b1, 1'b0, 2'b10, 32'h2C, 32'h44444444, 3, 1'b1);   run(2);
        issue(0, 1'b1, 1'b0, 2'b00, 32'h30, 32'h00000055, 0, 1'b1);   run(1);
        issue(1, 1'b0, 1'b1, 2'b00, 32'h30, 32'h0, 0, 1'b1);
        issue(0, 1'b0, 1'b0, 2'b10, 32'h24, 32'h0, 4, 1'b1);          run(2);

        issue(1, 1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("capture_read_low", mem_read, 1'b0);
        chk("capture_addr_held", mem_addr, 32'h10);
        exp_strobes++;
        rst_n = 1'b0;
        m1_req = 1'b0;
        #1;
        outs = m0_rdata | m1_rdata | mem_addr | mem_wdata
             | {26'h0, m0_ack, m0_err, m1_ack, m1_err, mem_read | mem_write | mem_sign, mem_size[0] | mem_size[1]};
        chk("async_reset_outputs", outs, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) seen++;
        end
        chk("no_ack_after_abort", seen, 0);
        issue(0, 1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, 1'b1);          run(1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 18, SHALL give the byte-address width of the shared SRAM.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 mN_req  input  1  (N=0,1) SHALL be the requester N access request, held until mN_ack.
REQ-005 mN_we  input  1  SHALL select write (1) or read (0).
REQ-006 mN_sign  input  1  SHALL select signed (0) or unsigned (1) read extension.
REQ-007 mN_size  input  2  SHALL select BYTE=00, HALF=01, WORD=10.
REQ-008 mN_addr  input  32  SHALL be the byte address.
REQ-009 mN_wdata  input  32  SHALL be the write data, right-aligned.
REQ-010 mN_ack  output  1  SHALL be a one-cycle completion pulse.
REQ-011 mN_err  output  1  SHALL be valid with mN_ack; 1 means the access was rejected.
REQ-012 mN_rdata  output  32  SHALL be the registered read result, valid with mN_ack on reads.
REQ-013 mem_read, mem_write  output  1 each  SHALL be the SRAM data-port strobes.
REQ-014 mem_sign  output  1, mem_size  output  2, mem_addr  output  32, mem_wdata  output  32  SHALL be the SRAM data-port command fields.
REQ-015 mem_rdata  input  32  SHALL be the SRAM sliced read data, valid the cycle after mem_read.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, CAPTURE, DONE.
REQ-017 In IDLE, on any mN_req, the block SHALL grant one requester, latch its we/sign/size/addr/wdata, and record the grant.
REQ-018 Arbitration SHALL be round-robin: a single requester wins; if both request, the requester not granted last wins.
REQ-019 A request SHALL be rejected (err) if addr >= 2**ADDR_WIDTH, size=11, HALF with addr[0]=1, or WORD with addr[1:0]!=00.
REQ-020 A rejected request SHALL go IDLE->DONE with no mem strobe; mN_err=1 with mN_ack.
REQ-021 ACCESS SHALL last one cycle with mem_write=we or mem_read=!we, and mem_* fields driven from latched values.
REQ-022 ACCESS SHALL go to DONE for writes and to CAPTURE for reads.
REQ-023 CAPTURE SHALL hold mem_sign/mem_size/mem_addr, drive mem_read=0, and load mem_rdata into the granted mN_rdata.
REQ-024 DONE SHALL assert the granted mN_ack for exactly one cycle, then return to IDLE.
REQ-025 The non-granted requester's ack, err and rdata SHALL be unchanged.
REQ-026 Latency from the IDLE edge sampling req to ack SHALL be 2 cycles for writes, 3 for reads, 1 for errors.
REQ-027 mN_req high in the IDLE cycle after DONE SHALL be treated as a new request; a requester SHALL drop req on the edge where it sees ack.
REQ-028 In IDLE, mem_read, mem_write and all mem_* fields SHALL be 0.
REQ-029 The latched command SHALL ignore input changes after grant.
REQ-030 mN_rdata SHALL change only in CAPTURE for the granted requester.

Reset
REQ-031 rst_n low SHALL force IDLE, all outputs 0, mN_rdata 0, last-grant=1 (m0 wins the first tie), asynchronously.
REQ-032 Reset mid-operation SHALL abort the access with no ack; a strobe SHALL not persist past reset assertion.
REQ-033 After rst_n rises, the first request SHALL be sampled no earlier than the next rising edge.

Verification
REQ-034 m0 write WORD addr 0x10 data 0xDEADBEEF -> mem_write=1 one cycle, m0_ack 2 cycles later, err=0.
REQ-035 m1 read BYTE signed addr 0x11 after the above -> mem_read=1 one cycle, m1_ack after 3 cycles, m1_rdata=0xFFFFFFBE.
REQ-036 m0 and m1 request together from reset, then again -> m0 granted first, m1 second, then m0 (alternating).
REQ-037 m0 HALF read addr 0x3, then WORD addr 0x40000 (ADDR_WIDTH=18) -> each m0_ack with m0_err=1 after 1 cycle, no mem strobe.
REQ-038 rst_n pulsed low during CAPTURE of an m1 read -> no m1_ack, all outputs 0, next m0 request served normally.
